// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
//   state_e          : loader FSM state encoding
//   BYTES_PER_WORD   : stream bytes per memory word
//   BYTE_CNT_WIDTH   : width of the byte-in-word counter
//   CHECKSUM_WIDTH   : width of the optional running XOR checksum
package loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_CNT_WIDTH = 2;
  localparam int unsigned CHECKSUM_WIDTH = 32;

  typedef enum logic [1:0] {
    StIdle,
    StAssemble,
    StWrite,
    StFinish
  } state_e;

endpackage

// File: rtl/byte_assembler.sv
// Collects a little-endian byte stream into 32-bit words.
//   clk_i       : clock
//   rst_i       : synchronous active-high reset
//   clear_i     : restart the byte counter at byte 0
//   accept_i    : a byte is taken from data_i this cycle
//   data_i      : stream byte
//   word_o      : assembled word (byte k in bits [8k+7:8k])
//   word_full_o : the byte taken this cycle completes the word
module byte_assembler
  import loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  data_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);

  logic [BYTE_CNT_WIDTH-1:0] byte_cnt_q, byte_cnt_d;
  logic [31:0]               word_q, word_d;

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    if (clear_i) begin
      byte_cnt_d = '0;
    end else if (accept_i) begin
      word_d[8*byte_cnt_q +: 8] = data_i;
      // Counter wraps back to 0 after the last byte of a word.
      byte_cnt_d = byte_cnt_q + BYTE_CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      byte_cnt_q <= '0;
      word_q     <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
    end
  end

  assign word_o      = word_q;
  assign word_full_o = accept_i && (byte_cnt_q == BYTE_CNT_WIDTH'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a byte stream into a word-addressed memory, one write strobe per word.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to add a CHECKSUM output
// holding the XOR of all words written by the current load.
//   CLK, RESET     : clock, synchronous active-high reset
//   START, LEN_W   : begin a load of LEN_W words (sampled in idle only)
//   IN_VALID/DATA  : byte stream in, IN_READY handshake out
//   ADDR_W, D_W, WE: memory write port
//   BUSY, DONE     : status, DONE pulses one cycle at end of load
//   CHECKSUM       : running XOR of written words (optional)
module imem_loader
  import loader_pkg::*;
#(
  parameter int unsigned addr_width = 10,
  parameter int unsigned data_width = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic [addr_width:0]   LEN_W,
  input  logic                  IN_VALID,
  input  logic [7:0]            IN_DATA,
  output logic                  IN_READY,
  output logic [addr_width-1:0] ADDR_W,
  output logic [data_width-1:0] D_W,
  output logic                  WE,
  output logic                  BUSY,
  output logic                  DONE
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [CHECKSUM_WIDTH-1:0] CHECKSUM
`endif
);

  localparam logic [addr_width:0] MaxLen = {1'b1, {addr_width{1'b0}}};
  localparam logic [addr_width:0] One    = {{addr_width{1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [addr_width:0]   len_q, len_d;
  logic [addr_width:0]   word_cnt_q, word_cnt_d;
  logic [addr_width:0]   word_cnt_inc;
  logic                  start_any;
  logic                  start_load;
  logic                  accept;
  logic                  word_full;
  logic [31:0]           word;

  assign start_any    = (state_q == StIdle) && START;
  assign start_load   = start_any && (LEN_W != '0);
  assign accept       = IN_VALID && IN_READY;
  assign word_cnt_inc = word_cnt_q + One;

  byte_assembler u_byte_assembler (
    .clk_i       (CLK),
    .rst_i       (RESET),
    .clear_i     (start_load || (state_q == StWrite)),
    .accept_i    (accept),
    .data_i      (IN_DATA),
    .word_o      (word),
    .word_full_o (word_full)
  );

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (START) state_d = (LEN_W == '0) ? StFinish : StAssemble;
      end
      StAssemble: begin
        if (word_full) state_d = StWrite;
      end
      StWrite: begin
        state_d = (word_cnt_inc == len_q) ? StFinish : StAssemble;
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    IN_READY = (state_q == StAssemble);
    WE       = (state_q == StWrite);
    DONE     = (state_q == StFinish);
    BUSY     = (state_q != StIdle);
  end

  // Length latch and word counter
  always_comb begin
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    if (start_load) begin
      // Oversized requests are clamped so addresses never wrap.
      len_d      = (LEN_W > MaxLen) ? MaxLen : LEN_W;
      word_cnt_d = '0;
    end else if (state_q == StWrite) begin
      word_cnt_d = word_cnt_inc;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      len_q      <= '0;
      word_cnt_q <= '0;
    end else begin
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign ADDR_W = word_cnt_q[addr_width-1:0];
  assign D_W    = word;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [CHECKSUM_WIDTH-1:0] checksum_q, checksum_d;

  // Updated on the WE cycle, so the value is settled by the DONE cycle.
  always_comb begin
    checksum_d = checksum_q;
    if (start_any) begin
      checksum_d = '0;
    end else if (WE) begin
      checksum_d = checksum_q ^ word;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign CHECKSUM = checksum_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int unsigned AW = 2;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          START;
  logic [AW:0]   LEN_W;
  logic          IN_VALID;
  logic [7:0]    IN_DATA;
  logic          IN_READY;
  logic [AW-1:0] ADDR_W;
  logic [31:0]   D_W;
  logic          WE;
  logic          BUSY;
  logic          DONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]   CHECKSUM;
`endif

  imem_loader #(
    .addr_width (AW),
    .data_width (32)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .START    (START),
    .LEN_W    (LEN_W),
    .IN_VALID (IN_VALID),
    .IN_DATA  (IN_DATA),
    .IN_READY (IN_READY),
    .ADDR_W   (ADDR_W),
    .D_W      (D_W),
    .WE       (WE),
    .BUSY     (BUSY),
    .DONE     (DONE)
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    .CHECKSUM (CHECKSUM)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit            is_done;
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [31:0]   chk;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] words[$];
  int          tests_run    = 0;
  int          tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every WE or DONE the DUT presents.
  always @(negedge CLK) begin
    exp_t e;
    if (WE === 1'b1 || DONE === 1'b1) begin
      tests_run++;
      if ((WE && DONE) || IN_READY) begin
        tests_failed++;
        $display("FAIL exclusivity: WE=%0b DONE=%0b IN_READY=%0b", WE, DONE, IN_READY);
      end
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected event: WE=%0b DONE=%0b ADDR_W=%0d expected none", WE, DONE,
                 ADDR_W);
      end else begin
        e = sb.pop_front();
        if (e.is_done) begin
          if (DONE !== 1'b1 || WE !== 1'b0) begin
            tests_failed++;
            $display("FAIL done event: got WE=%0b DONE=%0b expected DONE", WE, DONE);
          end
`ifdef IMEM_LOADER_CHECKSUM_EN
          tests_run++;
          if (CHECKSUM !== e.chk) begin
            tests_failed++;
            $display("FAIL checksum: got 0x%08h expected 0x%08h", CHECKSUM, e.chk);
          end
`endif
        end else if (WE !== 1'b1 || ADDR_W !== e.addr || D_W !== e.data) begin
          tests_failed++;
          $display("FAIL write event: got WE=%0b addr=%0d data=0x%08h expected addr=%0d data=0x%08h",
                   WE, ADDR_W, D_W, e.addr, e.data);
        end
      end
    end
  end

  task automatic push_we(input int addr, input logic [31:0] data);
    exp_t e;
    e.is_done = 1'b0;
    e.addr    = AW'(addr);
    e.data    = data;
    e.chk     = '0;
    sb.push_back(e);
  endtask

  task automatic push_done(input logic [31:0] chk);
    exp_t e;
    e.is_done = 1'b1;
    e.addr    = '0;
    e.data    = '0;
    e.chk     = chk;
    sb.push_back(e);
  endtask

  task automatic do_start(input logic [AW:0] len);
    START = 1'b1;
    LEN_W = len;
    @(posedge CLK);
    #1;
    START = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    bit acc = 1'b0;
    int n   = 0;
    IN_VALID = 1'b1;
    IN_DATA  = b;
    while (!acc) begin
      @(negedge CLK);
      acc = IN_READY;
      @(posedge CLK);
      #1;
      n++;
      if (!acc && n > 50) begin
        tests_run++;
        tests_failed++;
        $display("FAIL byte handshake: got no IN_READY expected within 50 cycles");
        break;
      end
    end
    IN_VALID = 1'b0;
    if (gap) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      if (sb.size() == 0 && BUSY === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    check("load completes", 32'(ok), 32'd1);
    @(posedge CLK);
    #1;
  endtask

  // Full load of the words queue; nexp words are expected to be written.
  task automatic run_load(input logic [AW:0] len, input int nexp, input bit gap);
    logic [31:0] chk = '0;
    for (int i = 0; i < nexp; i++) begin
      push_we(i, words[i]);
      chk ^= words[i];
    end
    push_done(chk);
    do_start(len);
    for (int i = 0; i < nexp; i++) send_word(words[i], gap);
    wait_idle();
  endtask

  initial begin
    RESET    = 1'b1;
    START    = 1'b0;
    LEN_W    = '0;
    IN_VALID = 1'b0;
    IN_DATA  = '0;
    repeat (2) @(posedge CLK);
    #1;
    @(negedge CLK);
    check("reset BUSY", 32'(BUSY), 32'd0);
    check("reset IN_READY", 32'(IN_READY), 32'd0);
    check("reset ADDR_W", 32'(ADDR_W), 32'd0);
    check("reset D_W", D_W, 32'd0);
    RESET = 1'b0;
    @(posedge CLK);
    #1;

    // Single word with latency checks.
    push_we(0, 32'h12345678);
    push_done(32'h12345678);
    do_start(3'd1);
    send_byte(8'h78, 1'b0);
    send_byte(8'h56, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h12, 1'b0);
    @(negedge CLK);
    check("WE cycle after byte 3", 32'(WE), 32'd1);
    check("D_W single word", D_W, 32'h12345678);
    @(negedge CLK);
    check("DONE cycle after WE", 32'(DONE), 32'd1);
    wait_idle();

    // Three words with IN_VALID toggling.
    words = '{32'hDEADBEEF, 32'h01020304, 32'hA5A55A5A};
    run_load(3'd3, 3, 1'b1);

    // Zero-length load.
    push_done(32'h0);
    do_start(3'd0);
    @(negedge CLK);
    check("len0 DONE", 32'(DONE), 32'd1);
    check("len0 BUSY", 32'(BUSY), 32'd1);
    check("len0 WE", 32'(WE), 32'd0);
    @(negedge CLK);
    check("len0 BUSY after", 32'(BUSY), 32'd0);
    check("len0 DONE after", 32'(DONE), 32'd0);
    @(posedge CLK);
    #1;

    // Reset in the middle of word 1.
    push_we(0, 32'h11223344);
    do_start(3'd2);
    send_word(32'h11223344, 1'b0);
    send_byte(8'h99, 1'b0);
    send_byte(8'h88, 1'b0);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    @(negedge CLK);
    check("abort BUSY", 32'(BUSY), 32'd0);
    check("abort ADDR_W", 32'(ADDR_W), 32'd0);
    check("abort D_W", D_W, 32'd0);
    check("abort IN_READY", 32'(IN_READY), 32'd0);
    RESET = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
    check("abort no pending", 32'(sb.size()), 32'd0);
    words = '{32'hCAFEF00D};
    run_load(3'd1, 1, 1'b0);

    // START mid-load is ignored.
    push_we(0, 32'h0BADC0DE);
    push_we(1, 32'h76543210);
    push_done(32'h0BADC0DE ^ 32'h76543210);
    do_start(3'd2);
    send_byte(8'hDE, 1'b0);
    send_byte(8'hC0, 1'b0);
    do_start(3'd4);
    send_byte(8'hAD, 1'b0);
    send_byte(8'h0B, 1'b0);
    send_word(32'h76543210, 1'b0);
    wait_idle();

    // Checksum pattern.
    words = '{32'hFFFF0000, 32'h0000FFFF};
    run_load(3'd2, 2, 1'b0);

    // Oversized length clamps to the full address space.
    words = '{32'h00000001, 32'h00000002, 32'h00000004, 32'h00000008};
    run_load(3'd7, 4, 1'b0);

    repeat (4) @(posedge CLK);
    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The module SHALL have parameter addr_width, default 10, meaning the width of the word address of the target memory.
REQ-002 The module SHALL have parameter data_width, default 32, meaning the memory word width; fixed at 32 for this block.
REQ-003 The module SHALL have one clock; reset is synchronous and active-high.
REQ-004 Port CLK, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 Port RESET, input, 1 bit: synchronous active-high reset.
REQ-006 Port START, input, 1 bit: begin a load; sampled only in IDLE.
REQ-007 Port LEN_W, input, addr_width+1 bits: number of words to load, sampled with START.
REQ-008 Port IN_VALID, input, 1 bit: byte available on IN_DATA.
REQ-009 Port IN_DATA, input, 8 bits: stream byte, little-endian within a word.
REQ-010 Port IN_READY, output, 1 bit: loader accepts a byte this cycle.
REQ-011 Port ADDR_W, output, addr_width bits: memory write address.
REQ-012 Port D_W, output, data_width bits: memory write data.
REQ-013 Port WE, output, 1 bit: memory write strobe, one cycle per word.
REQ-014 Port BUSY, output, 1 bit: high in every state except IDLE.
REQ-015 Port DONE, output, 1 bit: one-cycle completion pulse.

Function
REQ-016 The FSM SHALL have states IDLE, ASSEMBLE, WRITE and FINISH.
REQ-017 In IDLE, START=1 with LEN_W>0 SHALL latch LEN_W, clear the word counter and byte counter, and go to ASSEMBLE.
REQ-018 In IDLE, START=1 with LEN_W=0 SHALL go directly to FINISH without asserting WE.
REQ-019 IN_READY SHALL be 1 only in ASSEMBLE; a byte is accepted when IN_VALID and IN_READY are both 1.
REQ-020 Byte k (k=0..3) of a word SHALL land in D_W bits [8k+7:8k]; cycles with IN_VALID=0 hold all state.
REQ-021 Acceptance of byte 3 SHALL move the FSM to WRITE; in WRITE, WE=1 for exactly one cycle with ADDR_W equal to the word counter and D_W the assembled word.
REQ-022 After WRITE the word counter SHALL increment; if it equals the latched length the FSM goes to FINISH, otherwise to ASSEMBLE with the byte counter at 0.
REQ-023 FINISH SHALL last one cycle with DONE=1, then return to IDLE.
REQ-024 Latency: WE rises the cycle after byte 3 is accepted; DONE rises the cycle after the last WE.
REQ-025 LEN_W=2^addr_width SHALL write every address 0..2^addr_width-1 with no wrap; larger values SHALL be saturated to 2^addr_width.
REQ-026 START outside IDLE SHALL be ignored.
REQ-027 WE and DONE SHALL never be 1 in the same cycle, and neither is 1 when IN_READY is 1.

Reset
REQ-028 RESET=1 SHALL force IDLE, counters 0, IN_READY=0, WE=0, BUSY=0, DONE=0, ADDR_W=0, D_W=0 at the next edge.
REQ-029 RESET during ASSEMBLE or WRITE SHALL abort the load with no further WE and no DONE pulse, and RESET has priority over START.

Configuration
REQ-030 With macro IMEM_LOADER_CHECKSUM_EN defined, output port CHECKSUM (32 bits) SHALL exist, cleared on load start and XOR-updated with each written word on its WE cycle, so it is stable and valid while DONE=1.
REQ-031 Without IMEM_LOADER_CHECKSUM_EN, the CHECKSUM port and its logic SHALL be absent, and all other behaviour is identical.

Structure
REQ-032 Package loader_pkg SHALL hold the FSM state typedef, BYTES_PER_WORD=4 and the checksum width constant.
REQ-033 Sub-module byte_assembler (byte counter, shift/merge into a 32-bit word, word_full flag) SHALL be instantiated once in imem_loader.

Verification
REQ-034 START, LEN_W=1, bytes 0x78,0x56,0x34,0x12 -> one WE with ADDR_W=0, D_W=0x12345678, DONE the next cycle.
REQ-035 LEN_W=3, 12 bytes with IN_VALID toggling every other cycle -> WE at ADDR_W=0,1,2 with correct words, one DONE pulse.
REQ-036 START with LEN_W=0 -> no WE, DONE pulses one cycle after START, BUSY high for one cycle.
REQ-037 RESET asserted after 2 of 4 bytes of word 1 (LEN_W=2) -> no further WE and no DONE; a new load with LEN_W=1 then writes ADDR_W=0 correctly.
REQ-038 START pulsed mid-load (LEN_W=2) -> ignored, exactly 2 WEs and one DONE.
REQ-039 With IMEM_LOADER_CHECKSUM_EN defined, words 0xFFFF0000 and 0x0000FFFF -> CHECKSUM=0xFFFFFFFF while DONE=1.
